// File: rtl/io_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_tx_if
//  Description : CPU-side IO port bundle for the UART transmitter: the IO64
//                output word (byte + request toggle), the IO65 status word
//                and the serial TXD line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_uart_tx_if;
  logic [15:0] io64;  // [7:0] tx byte, [8] request toggle, [15:9] ignored
  logic [15:0] io65;  // [0] busy, [1] ack toggle, [15:2] zero
  logic        txd;   // serial line, idle high

  // CPU / test side drives the request word and observes status and line
  modport master (
    output io64,
    input  io65,
    input  txd
  );

  // Transmitter side
  modport slave (
    input  io64,
    output io65,
    output txd
  );
endinterface
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter. A request is a toggle of
//                IO64[8]; the block acknowledges by copying that toggle into
//                IO65[1] on the edge that starts the frame. Bytes go out LSB
//                first. Back-to-back requests follow the stop bit with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  wire          clk,
  input  wire          rst,
  io_uart_tx_if.slave  bus
);

  // A one-bit counter is the minimum even when CLKS_PER_BIT is 2
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state;
  logic                req_q;
  logic [7:0]          data_q;
  logic                ack;
  logic                busy;
  logic                txd_r;
  logic [7:0]          shreg;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;

  logic                pending;
  logic                baud_done;
  logic                unused_bits;

  // Request detection is a level compare, so an even number of toggles
  // before the accept edge cancels out.
  assign pending   = (req_q != ack);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Upper half of IO64 carries nothing for this block
  assign unused_bits = ^bus.io64[15:9];

  assign bus.io65 = {14'b0, ack, busy};
  assign bus.txd  = txd_r;

  // Input capture, frame sequencing and registered status/line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      data_q   <= 8'h00;
      ack      <= 1'b0;
      busy     <= 1'b0;
      txd_r    <= 1'b1;
      shreg    <= 8'h00;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else begin
      req_q  <= bus.io64[8];
      data_q <= bus.io64[7:0];

      case (state)
        S_IDLE: begin
          txd_r <= 1'b1;
          if (pending) begin
            // Accept: the byte is taken from the registered copy, so the
            // latest write before this edge wins.
            state    <= S_START;
            shreg    <= data_q;
            ack      <= req_q;
            busy     <= 1'b1;
            txd_r    <= 1'b0;
            baud_cnt <= '0;
          end
        end

        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            txd_r    <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              txd_r <= 1'b1;
            end else begin
              // Next bit is shreg[1] because the register shifts this edge
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd_r   <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pending) begin
              // Chain straight into the next frame without an idle cycle
              state <= S_START;
              shreg <= data_q;
              ack   <= req_q;
              busy  <= 1'b1;
              txd_r <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              txd_r <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          txd_r    <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart_tx
//  Description : Bench for io_uart_tx with CLKS_PER_BIT=4. A frame-position
//                model predicts TXD and IO65 every cycle; directed scenarios
//                pin literal values, then randomized writes exercise it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

  localparam int C = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  io_uart_tx_if bus ();

  io_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: input register copy, ack, and position within the current frame
  logic       m_on;
  logic       m_req;
  logic [7:0] m_data;
  logic       m_ack;
  logic       m_busy;
  int         m_pos;
  logic [7:0] m_byte;
  logic       m_pend;

  initial begin
    m_on = 1'b0; m_req = 1'b0; m_data = 8'h00; m_ack = 1'b0;
    m_busy = 1'b0; m_pos = 0; m_byte = 8'h00; m_pend = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Line level as a function of how far into the 10-bit frame we are
  function automatic logic exp_txd();
    int k;
    k = m_pos / C;
    if (!m_busy) return 1'b1;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  // Advance the model one clock
  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_req = 1'b0; m_data = 8'h00; m_ack = 1'b0;
      m_busy = 1'b0; m_pos = 0; m_byte = 8'h00;
    end else begin
      m_pend = (m_req != m_ack);
      if (m_busy) begin
        m_pos++;
        if (m_pos == 10 * C) begin
          if (m_pend) begin
            m_pos = 0; m_byte = m_data; m_ack = m_req;
          end else begin
            m_busy = 1'b0;
          end
        end
      end else if (m_pend) begin
        m_busy = 1'b1; m_pos = 0; m_byte = m_data; m_ack = m_req;
      end
      m_req  = bus.io64[8];
      m_data = bus.io64[7:0];
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_on) begin
      chk("model_txd", {31'b0, bus.txd}, {31'b0, exp_txd()});
      chk("model_io65", {16'b0, bus.io65}, {16'b0, 14'b0, m_ack, m_busy});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Check the 8 data bits of a frame that entered START at the current negedge
  task automatic check_bits(input string name, input logic [7:0] pat);
    for (int k = 0; k < 8; k++) begin
      steps(C);
      chk(name, {31'b0, bus.txd}, {31'b0, pat[k]});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected under 3000000", $time);
    $fatal(1, "watchdog");
  end

  logic       cur_req;
  logic [7:0] rnd_byte;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.io64 = 16'h0000;
    @(negedge clk);
    steps(2);
    chk("reset_txd", {31'b0, bus.txd}, 32'd1);
    chk("reset_io65", {16'b0, bus.io65}, 32'h0);
    rst = 1'b0;
    steps(3);
    chk("idle_io65", {16'b0, bus.io65}, 32'h0);
    chk("idle_txd", {31'b0, bus.txd}, 32'd1);

    // Byte 0x55: one edge to register, frame begins on the next
    bus.io64 = 16'h0155;
    step();
    chk("lat_edge1_io65", {16'b0, bus.io65}, 32'h0);
    step();
    chk("lat_edge2_txd", {31'b0, bus.txd}, 32'd0);
    chk("lat_edge2_io65", {16'b0, bus.io65}, 32'h3);
    check_bits("bits_55", 8'h55);
    steps(C);
    chk("stop_55_txd", {31'b0, bus.txd}, 32'd1);
    chk("stop_55_io65", {16'b0, bus.io65}, 32'h3);
    steps(C);
    chk("end_55_io65", {16'b0, bus.io65}, 32'h2);

    // Data change without toggle while ack already matches: no frame
    bus.io64 = 16'h01FF;
    steps(12);
    chk("notoggle_io65", {16'b0, bus.io65}, 32'h2);
    chk("notoggle_txd", {31'b0, bus.txd}, 32'd1);

    // Back-to-back: second request written mid-frame follows the stop bit
    bus.io64 = 16'h0011;
    steps(2);
    chk("b2b_first_io65", {16'b0, bus.io65}, 32'h1);
    steps(5);
    bus.io64 = 16'h01A3;
    steps(35);
    chk("b2b_second_txd", {31'b0, bus.txd}, 32'd0);
    chk("b2b_second_io65", {16'b0, bus.io65}, 32'h3);
    check_bits("bits_a3", 8'hA3);
    steps(2 * C);
    chk("b2b_end_io65", {16'b0, bus.io65}, 32'h2);

    // Two toggles inside a frame cancel out
    bus.io64 = 16'h0000;
    steps(5);
    bus.io64 = 16'h0100;
    steps(3);
    bus.io64 = 16'h0000;
    steps(34);
    chk("dbl_end_io65", {16'b0, bus.io65}, 32'h0);
    steps(10);
    chk("dbl_after_io65", {16'b0, bus.io65}, 32'h0);
    chk("dbl_after_txd", {31'b0, bus.txd}, 32'd1);

    // Reset in data bit 3 with the request toggle left high
    bus.io64 = 16'h0177;
    steps(2);
    steps(C + 3 * C + 1);
    rst = 1'b1;
    step();
    chk("rst_mid_txd", {31'b0, bus.txd}, 32'd1);
    chk("rst_mid_io65", {16'b0, bus.io65}, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rst_rel1_txd", {31'b0, bus.txd}, 32'd1);
    step();
    chk("rst_rel2_txd", {31'b0, bus.txd}, 32'd0);
    chk("rst_rel2_io65", {16'b0, bus.io65}, 32'h3);
    steps(10 * C + 2);

    // Randomized writes, toggles and occasional resets
    cur_req = bus.io64[8];
    for (int it = 0; it < 250; it++) begin
      steps($urandom_range(0, 50));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        steps($urandom_range(1, 2));
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) cur_req = ~cur_req;
      rnd_byte = 8'($urandom);
      bus.io64 = {7'($urandom), cur_req, rnd_byte};
    end
    steps(12 * C * 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
